// File: rtl/elevator_pkg.sv
// Shared types and constants for the four-floor elevator controller.
// Request vector layout: car calls [3:0], hall-up [6:4] (floors 1..3), hall-down [9:7] (floors 2..4).
package elevator_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_UP    = 3'd1,
      S_DOWN  = 3'd2,
      S_OPEN  = 3'd3,
      S_CLOSE = 3'd4
   } state_e;

   localparam int NUM_FLOORS = 4;

   localparam int DEF_FLOOR_CYCLES = 10;
   localparam int DEF_DOOR_CYCLES  = 20;
   localparam int DEF_CLOSE_CYCLES = 4;

   localparam int REQ_W   = 10;
   localparam int CAR_LSB = 0;
   localparam int UP_LSB  = 4;
   localparam int DN_LSB  = 7;

endpackage

// File: rtl/elevator_requests.sv
// Sticky call latches plus the SCAN decode (calls above/below, stop at the evaluated floor).
// Decode and clear live in separate blocks so the clear, which depends on the next state, forms no loop.
module elevator_requests
   import elevator_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [REQ_W-1:0] req_in,
   input  logic [1:0]       floor,
   input  logic             dir,
   input  logic             clr_en,
   output logic             any_above,
   output logic             any_below,
   output logic             stop_here,
   output logic             opp_here
);

   logic [REQ_W-1:0]      req_q, req_d, pending, clr_mask;
   logic [NUM_FLOORS-1:0] car, up, dn, call_at, sel;
   logic                  same_here, beyond;

   always_comb begin
      pending   = req_q | req_in;
      car       = pending[CAR_LSB +: NUM_FLOORS];
      up        = {1'b0, pending[UP_LSB +: NUM_FLOORS-1]};
      dn        = {pending[DN_LSB +: NUM_FLOORS-1], 1'b0};
      call_at   = car | up | dn;
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (i > int'(floor)) any_above = any_above | call_at[i];
         if (i < int'(floor)) any_below = any_below | call_at[i];
      end
      same_here = dir ? up[floor] : dn[floor];
      opp_here  = dir ? dn[floor] : up[floor];
      beyond    = dir ? any_above : any_below;
      // An opposite hall call is only served here once nothing remains ahead.
      stop_here = car[floor] | same_here | (opp_here & ~beyond);
   end

   always_comb begin
      sel      = 4'b0001 << floor;
      clr_mask = {sel[3:1] & {3{~dir | ~beyond}},
                  sel[2:0] & {3{dir | ~beyond}},
                  sel} & {REQ_W{clr_en}};
      req_d    = pending & ~clr_mask;
   end

   always_ff @(posedge clk) begin
      if (reset) req_q <= '0;
      else       req_q <= req_d;
   end

endmodule

// File: rtl/elevator_top.sv
// Four-floor collective (SCAN) elevator controller: FSM, travel/door timers, floor register.
// "Call at this floor" means a call this stop would serve, so every door opening clears what caused it.
module elevator_top
   import elevator_pkg::*;
#(
   parameter int FLOOR_CYCLES = DEF_FLOOR_CYCLES,
   parameter int DOOR_CYCLES  = DEF_DOOR_CYCLES,
   parameter int CLOSE_CYCLES = DEF_CLOSE_CYCLES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       door_sensor,
   input  logic       open_btn,
   input  logic       close_btn,
   input  logic       B1U,
   input  logic       B2D,
   input  logic       B2U,
   input  logic       B3D,
   input  logic       B3U,
   input  logic       B4D,
   input  logic       BF1,
   input  logic       BF2,
   input  logic       BF3,
   input  logic       BF4,
   output logic       door,
   output logic       dir,
   output logic [2:0] state
);

   localparam int CNT_MAX = (FLOOR_CYCLES > DOOR_CYCLES) ?
                            ((FLOOR_CYCLES > CLOSE_CYCLES) ? FLOOR_CYCLES : CLOSE_CYCLES) :
                            ((DOOR_CYCLES > CLOSE_CYCLES) ? DOOR_CYCLES : CLOSE_CYCLES);
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] FLOOR_LOAD = CNT_W'(FLOOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] DOOR_LOAD  = CNT_W'(DOOR_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLOSE_LOAD = CNT_W'(CLOSE_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       floor_q, floor_d;
   logic             dir_q, dir_d, door_q, door_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [REQ_W-1:0] req_in;
   logic             any_above, any_below, stop_here, opp_here;
   logic             expired, beyond, behind, flip, clr_en;

   assign req_in = {B4D, B3D, B2D, B3U, B2U, B1U, BF4, BF3, BF2, BF1};

   elevator_requests u_requests (
      .clk       (clk),
      .reset     (reset),
      .req_in    (req_in),
      .floor     (floor_d),
      .dir       (dir_q),
      .clr_en    (clr_en),
      .any_above (any_above),
      .any_below (any_below),
      .stop_here (stop_here),
      .opp_here  (opp_here)
   );

   // Requests are always judged at the floor the car occupies after this edge.
   always_comb begin
      floor_d = floor_q;
      if (cnt_q == '0) begin
         if (state_q == S_UP && floor_q != 2'(NUM_FLOORS - 1)) floor_d = floor_q + 2'd1;
         else if (state_q == S_DOWN && floor_q != 2'd0)        floor_d = floor_q - 2'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      expired = (cnt_q == '0);
      beyond  = dir_q ? any_above : any_below;
      behind  = dir_q ? any_below : any_above;
      flip    = ~beyond & (opp_here | behind);
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (stop_here || open_btn) begin
               state_d = S_OPEN;
               cnt_d   = DOOR_LOAD;
            end else if (any_above || any_below) begin
               cnt_d = FLOOR_LOAD;
               if (dir_q ? any_above : !any_below) begin
                  state_d = S_UP;
                  dir_d   = 1'b1;
               end else begin
                  state_d = S_DOWN;
                  dir_d   = 1'b0;
               end
            end
         end
         S_UP, S_DOWN: begin
            if (!expired) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (stop_here) begin
               state_d = S_OPEN;
               cnt_d   = DOOR_LOAD;
            end else if (!beyond) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = FLOOR_LOAD;
            end
         end
         S_OPEN: begin
            if (door_sensor || open_btn) begin
               cnt_d = DOOR_LOAD;
            end else if (close_btn || expired) begin
               state_d = S_CLOSE;
               cnt_d   = CLOSE_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_CLOSE: begin
            if (door_sensor || open_btn || stop_here) begin
               state_d = S_OPEN;
               cnt_d   = DOOR_LOAD;
            end else if (expired) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
      // Turn around on arrival only if something waits the other way.
      if (state_d == S_OPEN && state_q != S_OPEN && flip) dir_d = ~dir_q;
      door_d = (state_d == S_OPEN);
   end

   assign clr_en = (state_d == S_OPEN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         floor_q <= 2'd0;
         dir_q   <= 1'b1;
         door_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         floor_q <= floor_d;
         dir_q   <= dir_d;
         door_q  <= door_d;
         cnt_q   <= cnt_d;
      end
   end

   assign door  = door_q;
   assign dir   = dir_q;
   assign state = state_q;

endmodule

// File: tb/tb_elevator_top.sv
// Directed bench for elevator_top: a vector table walks the main scenarios,
// then hand-written sequences cover mid-travel reset, passing calls and late calls.
module tb_elevator_top;

   localparam logic [9:0] K_BF1 = 10'h001;
   localparam logic [9:0] K_BF2 = 10'h002;
   localparam logic [9:0] K_BF4 = 10'h008;
   localparam logic [9:0] K_B1U = 10'h010;
   localparam logic [9:0] K_B2D = 10'h080;
   localparam logic [9:0] K_B3D = 10'h100;
   localparam logic [2:0] C_SENS  = 3'b100;
   localparam logic [2:0] C_OPEN  = 3'b010;
   localparam logic [2:0] C_CLOSE = 3'b001;

   typedef struct {
      string      name;
      logic [9:0] btn;
      logic [2:0] ctl;
      int         hold;
      int         idle;
      logic [4:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] btn = '0;
   logic [2:0] ctl = '0;
   logic       door, dir;
   logic [2:0] state;

   vec_t       vecs[$];
   logic [4:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   elevator_top dut (
      .clk         (clk),
      .reset       (reset),
      .door_sensor (ctl[2]),
      .open_btn    (ctl[1]),
      .close_btn   (ctl[0]),
      .B1U         (btn[4]),
      .B2D         (btn[7]),
      .B2U         (btn[5]),
      .B3D         (btn[8]),
      .B3U         (btn[6]),
      .B4D         (btn[9]),
      .BF1         (btn[0]),
      .BF2         (btn[1]),
      .BF3         (btn[2]),
      .BF4         (btn[3]),
      .door        (door),
      .dir         (dir),
      .state       (state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      cycles(n);
      reset = 1'b0;
   endtask

   // drivers
   task automatic press(input logic [9:0] b, input logic [2:0] c, input int hold);
      btn = b;
      ctl = c;
      cycles(hold);
      btn = '0;
      ctl = '0;
   endtask

   function automatic logic [4:0] ex(input int st, input logic d, input logic r);
      logic [2:0] s;
      s = st[2:0];
      return {s, d, r};
   endfunction

   function automatic void add_vec(input string name, input logic [9:0] b, input logic [2:0] c,
                                   input int hold, input int idle, input logic [4:0] e);
      vec_t v;
      v.name = name;
      v.btn  = b;
      v.ctl  = c;
      v.hold = hold;
      v.idle = idle;
      v.exp  = e;
      vecs.push_back(v);
   endfunction

   // scoreboard
   task automatic sb_check(input string name);
      logic [4:0] got, want;
      got = {state, door, dir};
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: no expected value queued", name);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            errors++;
            $display("FAIL %s: got state=%0d door=%0b dir=%0b, expected state=%0d door=%0b dir=%0b",
                     name, got[4:2], got[1], got[0], want[4:2], want[1], want[0]);
         end
      end
   endtask

   task automatic expect_now(input string name, input logic [4:0] e);
      exp_q.push_back(e);
      sb_check(name);
   endtask

   initial begin
      // Scenario table; each row continues from where the previous one left the car.
      add_vec("idle_no_input",    '0,    '0,               1,  4, ex(0, 0, 1));
      add_vec("b1u_opens",        K_B1U, '0,               1,  0, ex(3, 1, 1));
      add_vec("open_last_cycle",  '0,    '0,               0, 19, ex(3, 1, 1));
      add_vec("close_entered",    '0,    '0,               0,  1, ex(4, 0, 1));
      add_vec("close_last_cycle", '0,    '0,               0,  3, ex(4, 0, 1));
      add_vec("idle_after_close", '0,    '0,               0,  1, ex(0, 0, 1));
      add_vec("bf4_departs_up",   K_BF4, '0,               1,  0, ex(1, 0, 1));
      add_vec("up_before_f4",     '0,    '0,               0, 29, ex(1, 0, 1));
      add_vec("open_at_f4",       '0,    '0,               0,  1, ex(3, 1, 1));
      add_vec("f4_close",         '0,    '0,               0, 20, ex(4, 0, 1));
      add_vec("f4_idle",          '0,    '0,               0,  4, ex(0, 0, 1));
      add_vec("bf4_cleared",      '0,    '0,               0,  5, ex(0, 0, 1));
      add_vec("b2d_departs_down", K_B2D, '0,               1,  0, ex(2, 0, 0));
      add_vec("down_before_f2",   '0,    '0,               0, 19, ex(2, 0, 0));
      add_vec("open_at_f2",       '0,    '0,               0,  1, ex(3, 1, 0));
      add_vec("f2_close",         '0,    '0,               0, 20, ex(4, 0, 0));
      add_vec("f2_idle_dir_down", '0,    '0,               0,  4, ex(0, 0, 0));
      add_vec("open_btn_idle",    '0,    C_OPEN,           1,  0, ex(3, 1, 0));
      add_vec("sensor_50",        '0,    C_SENS,          50,  0, ex(3, 1, 0));
      add_vec("release_19",       '0,    '0,               0, 19, ex(3, 1, 0));
      add_vec("release_20_close", '0,    '0,               0,  1, ex(4, 0, 0));
      add_vec("sensor_reopens",   '0,    C_SENS,           1,  0, ex(3, 1, 0));
      add_vec("close_btn_open",   '0,    C_CLOSE,          1,  0, ex(4, 0, 0));
      add_vec("sens_close_reopen",'0,    C_SENS | C_CLOSE, 1,  0, ex(3, 1, 0));
      add_vec("sensor_beats_close",'0,   C_SENS | C_CLOSE, 3,  0, ex(3, 1, 0));
      add_vec("open_beats_close", '0,    C_OPEN | C_CLOSE, 3,  0, ex(3, 1, 0));
      add_vec("close_btn_again",  '0,    C_CLOSE,          1,  0, ex(4, 0, 0));
      add_vec("back_to_idle",     '0,    '0,               0,  4, ex(0, 0, 0));

      do_reset(2);
      expect_now("reset_state", ex(0, 0, 1));

      for (int i = 0; i < vecs.size(); i++) begin
         press(vecs[i].btn, vecs[i].ctl, vecs[i].hold);
         cycles(vecs[i].idle);
         exp_q.push_back(vecs[i].exp);
         sb_check(vecs[i].name);
      end

      // Reset while travelling: car logically returns to floor 1, latched BF4 is dropped.
      press(K_BF4, '0, 1);
      expect_now("mid_reset_departs", ex(1, 0, 1));
      cycles(15);
      do_reset(2);
      expect_now("mid_reset_state", ex(0, 0, 1));
      press(K_B1U, '0, 1);
      expect_now("mid_reset_at_f1", ex(3, 1, 1));
      cycles(27);
      expect_now("mid_reset_bf4_gone", ex(0, 0, 1));

      // B3D pressed on the way up to BF4: pass floor 3, turn at 4, come back for 3.
      press(K_BF4, '0, 1);
      expect_now("scan_departs", ex(1, 0, 1));
      cycles(11);
      press(K_B3D, '0, 1);
      cycles(9);
      expect_now("scan_passes_f3", ex(1, 0, 1));
      cycles(9);
      expect_now("scan_f4_flip", ex(3, 1, 0));
      cycles(24);
      expect_now("scan_f4_idle", ex(0, 0, 0));
      cycles(1);
      expect_now("scan_heads_down", ex(2, 0, 0));
      cycles(10);
      expect_now("scan_serves_f3", ex(3, 1, 0));

      // Call for floor 2 arriving one cycle before the floor-2 expiry edge is still served.
      cycles(24);
      press(K_BF1, '0, 1);
      expect_now("late_departs", ex(2, 0, 0));
      cycles(9);
      press(K_BF2, '0, 1);
      expect_now("late_call_stop_f2", ex(3, 1, 0));
      cycles(25);
      expect_now("late_resumes_down", ex(2, 0, 0));
      cycles(10);
      expect_now("late_open_f1", ex(3, 1, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/elevator_top.md
# elevator_top

Four-floor elevator car controller: latches hall and car calls, runs a directional collective (SCAN) dispatch, times floor travel and door dwell, and drives the door and direction outputs. It is the top level of the elevator design. Button inputs and sensors come from the board, and `state` is exported for display and debug.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- `FLOOR_CYCLES`, default 10: clock cycles to travel one floor.
- `DOOR_CYCLES`, default 20: door-open dwell in cycles.
- `CLOSE_CYCLES`, default 4: door-closing interval in cycles.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `door_sensor`  in  1  obstruction; 1 = blocked.
- `open_btn`, `close_btn`  in  1 each  cabin door buttons.
- `B1U`, `B2D`, `B2U`, `B3D`, `B3U`, `B4D`  in  1 each  hall calls (floor, direction).
- `BF1`..`BF4`  in  1 each  cabin floor calls.
- `door`  out  1  1 = door open.
- `dir`  out  1  1 = up, 0 = down; holds the last travel direction.
- `state`  out  3  FSM state code.

## Operation
- State codes: IDLE=0, UP=1, DOWN=2, OPEN=3, CLOSE=4. Codes 5–7 are unreachable and recover to IDLE.
- The current floor is held internally as 0..3 (floor 1..4).
- Requests: each button sets a sticky request bit while high. Dispatch uses `pending = latched | live inputs`, so a press acts on the first edge it is seen.
- Stop rule at floor f:
  - Travelling up: stop on car call f, hall-up f, or hall-down f when no request exists above f.
  - Travelling down: mirror of the up rule.
  - Floors 1 and 4 stop on any call there.
- IDLE:
  - Request at the current floor, or `open_btn`, -> OPEN.
  - Otherwise, if requests exist in the `dir` direction, keep `dir`; else reverse.
  - Request above -> UP with `dir`=1. Request below -> DOWN with `dir`=0.
  - Nothing pending -> stay in IDLE.
- UP / DOWN: the counter runs FLOOR_CYCLES. On expiry the floor moves ±1, then:
  - stop rule true -> OPEN;
  - otherwise the counter reloads and the car keeps moving.
- OPEN, `door`=1:
  - Entry clears the car call at this floor and the hall call matching `dir`. If nothing is pending beyond this floor in `dir`, it also clears the opposite hall call and flips `dir`.
  - A new call at this floor while OPEN is cleared immediately.
  - The counter runs DOOR_CYCLES and reloads while `door_sensor` or `open_btn` is high.
  - Expiry, or `close_btn` with `door_sensor`=0 -> CLOSE.
- CLOSE, `door`=0: the counter runs CLOSE_CYCLES.
  - `door_sensor`, `open_btn`, or a call at this floor -> OPEN.
  - Expiry -> IDLE.
- `door` is 1 only in OPEN. The car never moves unless it is in UP or DOWN.

## Timing
- Reset values: state=IDLE (0), floor 1, `dir`=1, `door`=0, all requests cleared, counters 0.
- Reset has priority over every input. Reset asserted mid-travel returns to floor 1 instantly; this is a logical reset only.
- All outputs are registered.
- Latency: a button high before edge N causes the state change at edge N.
- OPEN lasts exactly DOOR_CYCLES cycles without sensor or buttons. CLOSE lasts CLOSE_CYCLES cycles.
- Travel takes k·FLOOR_CYCLES cycles for k floors.
- `close_btn` and `door_sensor` asserted together: the sensor wins and the door stays open.
- `open_btn` and `close_btn` asserted together: open wins.
- Calls pressed while moving are latched. A call at a floor the car is passing is served if it arrives before that floor's expiry edge.
- Simultaneous calls above and below from IDLE: the current `dir` is kept.

## Structure
- Package `elevator_pkg`:
  - state enum, floor count (4);
  - default cycle constants;
  - request-vector bit positions (car[3:0], up[2:0], down[3:1]).
- Sub-module `elevator_requests`:
  - latch/clear of the request bits;
  - `any_above`, `any_below`, `stop_here` logic.
- FSM, counters, floor register and outputs stay in `elevator_top`.

## Test plan
- Reset pulse of 2 cycles -> state=0, `door`=0, `dir`=1. Stays IDLE with no input.
- At floor 1, B1U held -> OPEN next edge; `door`=1 for 20 cycles, then CLOSE for 4, then IDLE.
- BF4 from floor 1 -> UP, `dir`=1, 30 cycles, then OPEN, `door`=1. BF4 request cleared.
- Car at floor 4, B2D -> DOWN, `dir`=0, 20 cycles, OPEN at floor 2. Afterwards IDLE with `dir`=0.
- `door_sensor` high during OPEN for 50 cycles -> door stays open. Closes 20 cycles after release.
- `door_sensor` high in CLOSE -> reopens. `close_btn` in OPEN -> CLOSE next edge.
- Car moving up from floor 1 to BF4, B3D pressed -> no stop at 3 on the way up. At floor 4, door open with `dir` flipped to 0, then the car serves 3.
